// File: rtl/adc_level_meter.sv
// adc_level_meter: averages ADC samples over 2^AVG_LOG2 valid strobes,
// quantises the average into LED_CNT levels and drives the LED bank as a
// bar or a single dot.
// Optional build macro ADC_LEVEL_METER_PEAK_HOLD_EN adds a peak marker
// that is held for HOLD_UPDATES windows, then decays one level every
// DECAY_UPDATES windows. Without it, peak reads 0 and no marker is shown.
module adc_level_meter #(
  parameter int ADC_RES       = 12,
  parameter int LED_CNT       = 8,
  parameter int AVG_LOG2      = 2,
  parameter int HOLD_UPDATES  = 64,
  parameter int DECAY_UPDATES = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [ADC_RES-1:0]               datain,
  input  logic                             datavalid,
  input  logic                             dotmode,
  output logic [LED_CNT-1:0]               ledsout,
  output logic [$clog2(LED_CNT+1)-1:0]     level,
  output logic [$clog2(LED_CNT+1)-1:0]     peak,
  output logic                             update
);

  localparam int LW        = $clog2(LED_CNT + 1);
  localparam int STEP_LOG2 = ADC_RES - $clog2(LED_CNT);
  localparam int AW        = ADC_RES + AVG_LOG2;
  // Window counter keeps one bit even when every sample closes a window.
  localparam int CW        = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CW-1:0]      WIN_LAST = CW'((1 << AVG_LOG2) - 1);
  localparam logic [ADC_RES:0]   STEP_M1  = (ADC_RES + 1)'((1 << STEP_LOG2) - 1);

  // Reject parameter sets the datapath widths cannot represent.
  if (AVG_LOG2 < 0 || AVG_LOG2 > 4 || LED_CNT < 2 ||
      (LED_CNT & (LED_CNT - 1)) != 0 || LED_CNT > (1 << ADC_RES) ||
      HOLD_UPDATES < 1 || DECAY_UPDATES < 1) begin : g_bad_param
    $error("adc_level_meter: illegal parameter set");
  end

  logic [AW-1:0]      acc_q, acc_d, sum;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               win_done;
  logic [ADC_RES-1:0] avg;
  logic [ADC_RES:0]   lvl_wide;
  logic [LW-1:0]      lvl;
  logic [LW-1:0]      level_q, level_d;
  logic [LW-1:0]      peak_q, peak_d;
  logic [LED_CNT-1:0] leds_q, leds_d;
  logic               update_q;

  // Window accumulation and average/level computation for the closing sample.
  always_comb begin
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sum      = acc_q + AW'(datain);
    win_done = datavalid && (cnt_q == WIN_LAST);
    avg      = ADC_RES'(sum >> AVG_LOG2);
    lvl_wide = {1'b0, avg} + STEP_M1;
    lvl      = LW'(lvl_wide >> STEP_LOG2);
    if (datavalid) begin
      if (win_done) begin
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + CW'(1);
      end
    end
    level_d = win_done ? lvl : level_q;
  end

`ifdef ADC_LEVEL_METER_PEAK_HOLD_EN
  localparam int HW = $clog2(HOLD_UPDATES + 1);
  localparam int DW = $clog2(DECAY_UPDATES + 1);

  logic [HW-1:0] hold_q, hold_d;
  logic [DW-1:0] decay_q, decay_d;

  // Peak follows rises immediately, holds, then decays toward the live level.
  always_comb begin
    peak_d  = peak_q;
    hold_d  = hold_q;
    decay_d = decay_q;
    if (win_done) begin
      if (lvl >= peak_q) begin
        peak_d  = lvl;
        hold_d  = HW'(HOLD_UPDATES);
        decay_d = '0;
      end else if (hold_q != '0) begin
        hold_d = hold_q - HW'(1);
      end else if (decay_q + DW'(1) == DW'(DECAY_UPDATES)) begin
        peak_d  = (peak_q - LW'(1) > lvl) ? peak_q - LW'(1) : lvl;
        decay_d = '0;
      end else begin
        decay_d = decay_q + DW'(1);
      end
    end
  end

  // Hold and decay counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q  <= '0;
      decay_q <= '0;
    end else begin
      hold_q  <= hold_d;
      decay_q <= decay_d;
    end
  end
`else
  // No peak marker in this build.
  always_comb begin
    peak_d = '0;
  end
`endif

  // LED pattern from next-state level/peak so dotmode changes show at once.
  always_comb begin
    leds_d = '0;
    for (int i = 0; i < LED_CNT; i++) begin
      if (dotmode) leds_d[i] = (i + 1 == int'(level_d));
      else         leds_d[i] = (i < int'(level_d));
`ifdef ADC_LEVEL_METER_PEAK_HOLD_EN
      if (i + 1 == int'(peak_d)) leds_d[i] = 1'b1;
`endif
    end
  end

  // Main state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      level_q  <= '0;
      peak_q   <= '0;
      leds_q   <= '0;
      update_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      level_q  <= level_d;
      peak_q   <= peak_d;
      leds_q   <= leds_d;
      update_q <= win_done;
    end
  end

  assign ledsout = leds_q;
  assign level   = level_q;
  assign peak    = peak_q;
  assign update  = update_q;

endmodule

// File: tb/tb_adc_level_meter.sv
// Bench for adc_level_meter: three instances (AVG_LOG2=0, AVG_LOG2=2, and a
// short hold/decay instance). Stimulus pushes expected window results into
// per-instance queues; monitors pop and compare whenever update is seen.
module tb_adc_level_meter;

`ifdef ADC_LEVEL_METER_PEAK_HOLD_EN
  localparam bit PK = 1'b1;
`else
  localparam bit PK = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [11:0] d0, d2, dp;
  logic        v0, v2, vp;
  logic        m0, m2, mp;
  logic [7:0]  led0, led2, ledp;
  logic [3:0]  lvl0, lvl2, lvlp;
  logic [3:0]  pk0, pk2, pkp;
  logic        up0, up2, upp;

  adc_level_meter #(.AVG_LOG2(0)) u0 (
    .clk(clk), .rst(rst), .datain(d0), .datavalid(v0), .dotmode(m0),
    .ledsout(led0), .level(lvl0), .peak(pk0), .update(up0));

  adc_level_meter #(.AVG_LOG2(2)) u2 (
    .clk(clk), .rst(rst), .datain(d2), .datavalid(v2), .dotmode(m2),
    .ledsout(led2), .level(lvl2), .peak(pk2), .update(up2));

  adc_level_meter #(.AVG_LOG2(0), .HOLD_UPDATES(4), .DECAY_UPDATES(2)) up (
    .clk(clk), .rst(rst), .datain(dp), .datavalid(vp), .dotmode(mp),
    .ledsout(ledp), .level(lvlp), .peak(pkp), .update(upp));

  typedef struct {
    int cyc;
    int lvl;
    int pk;
    int led;
  } exp_t;

  exp_t q0[$], q2[$], qp[$];
  exp_t e0, e2, ep;
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic compare(input string nm, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, req);
    end
  endtask

  task automatic check_upd(input string nm, input exp_t e,
                           input int l, input int p, input int d);
    compare({nm, " update cycle"}, cyc, e.cyc);
    compare({nm, " level"}, l, e.lvl);
    compare({nm, " peak"}, p, e.pk);
    compare({nm, " ledsout"}, d, e.led);
  endtask

  task automatic unexpected(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s unexpected update: got update=1 at cycle %0d required no update", nm, cyc);
  endtask

  // Monitors: one per instance, sampled 1 time unit after the rising edge.
  always @(posedge clk) begin
    #1;
    if (up0 === 1'b1) begin
      if (q0.size() == 0) unexpected("inst0");
      else begin
        e0 = q0.pop_front();
        check_upd("inst0", e0, int'(lvl0), int'(pk0), int'(led0));
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (up2 === 1'b1) begin
      if (q2.size() == 0) unexpected("inst2");
      else begin
        e2 = q2.pop_front();
        check_upd("inst2", e2, int'(lvl2), int'(pk2), int'(led2));
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (upp === 1'b1) begin
      if (qp.size() == 0) unexpected("instP");
      else begin
        ep = qp.pop_front();
        check_upd("instP", ep, int'(lvlp), int'(pkp), int'(ledp));
      end
    end
  end

  // Drive one instance for one cycle at the falling edge; others idle.
  task automatic drive(input int inst, input bit v, input int data, input bit dm);
    @(negedge clk);
    v0 = 1'b0; v2 = 1'b0; vp = 1'b0;
    case (inst)
      0: begin v0 = v; d0 = 12'(data); m0 = dm; end
      2: begin v2 = v; d2 = 12'(data); m2 = dm; end
      default: begin vp = v; dp = 12'(data); mp = dm; end
    endcase
  endtask

  // Result of the sample just driven is due after the next rising edge.
  task automatic push(input int inst, input int l, input int p, input int d);
    exp_t e;
    e.cyc = cyc + 1;
    e.lvl = l;
    e.pk  = p;
    e.led = d;
    case (inst)
      0: q0.push_back(e);
      2: q2.push_back(e);
      default: qp.push_back(e);
    endcase
  endtask

  int qin[6]  = '{0, 1, 512, 513, 2000, 4095};
  int qlv[6]  = '{0, 1, 1, 2, 4, 8};
  int qled[6] = '{8'h00, 8'h01, 8'h01, 8'h03, 8'h0F, 8'hFF};

  initial begin
    int pkv;

    // Reset with full-scale valid samples on every instance.
    rst = 1'b1;
    v0 = 1'b1; v2 = 1'b1; vp = 1'b1;
    d0 = 12'd4095; d2 = 12'd4095; dp = 12'd4095;
    m0 = 1'b0; m2 = 1'b0; mp = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      compare("reset inst0 outputs", int'({led0, lvl0, pk0, up0}), 0);
      compare("reset inst2 outputs", int'({led2, lvl2, pk2, up2}), 0);
      compare("reset instP outputs", int'({ledp, lvlp, pkp, upp}), 0);
    end
    v0 = 1'b0; v2 = 1'b0; vp = 1'b0;
    rst = 1'b0;

    // Quantisation, one sample per window, bar mode.
    for (int i = 0; i < 6; i++) begin
      drive(0, 1'b1, qin[i], 1'b0);
      push(0, qlv[i], PK ? qlv[i] : 0, qled[i]);
      drive(0, 1'b0, 0, 1'b0);
    end

    // Averaging over four back-to-back samples.
    drive(2, 1'b1, 0, 1'b0);
    drive(2, 1'b1, 0, 1'b0);
    drive(2, 1'b1, 0, 1'b0);
    drive(2, 1'b1, 4095, 1'b0);
    push(2, 2, PK ? 2 : 0, 8'h03);
    drive(2, 1'b0, 0, 1'b0);
    drive(2, 1'b0, 0, 1'b0);

    // Reset mid-window discards the partial sum.
    drive(2, 1'b1, 4095, 1'b0);
    drive(2, 1'b1, 4095, 1'b0);
    drive(2, 1'b0, 0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    v2 = 1'b1; d2 = 12'd0;
    drive(2, 1'b1, 0, 1'b0);
    drive(2, 1'b1, 0, 1'b0);
    drive(2, 1'b1, 0, 1'b0);
    push(2, 0, 0, 8'h00);
    drive(2, 1'b0, 0, 1'b0);

    // Peak hold then decay: 4 held updates, then one level per 2 updates.
    drive(3, 1'b1, 4095, 1'b0);
    push(3, 8, PK ? 8 : 0, 8'hFF);
    for (int k = 1; k <= 20; k++) begin
      drive(3, 1'b1, 0, 1'b0);
      pkv = (k <= 4) ? 8 : 8 - (k - 4) / 2;
      push(3, 0, PK ? pkv : 0, (PK && pkv > 0) ? (1 << (pkv - 1)) : 0);
    end

    // Dot mode with peak marker, then dotmode change without a new window.
    drive(3, 1'b1, 4095, 1'b0);
    push(3, 8, PK ? 8 : 0, 8'hFF);
    drive(3, 1'b1, 2000, 1'b1);
    push(3, 4, PK ? 8 : 0, PK ? 8'h88 : 8'h08);
    drive(3, 1'b0, 0, 1'b0);
    @(negedge clk);
    compare("instP dotmode refresh ledsout", int'(ledp), PK ? 8'h8F : 8'h0F);
    compare("instP no update on dotmode change", int'(upp), 0);

    for (int i = 0; i < 50 && (q0.size() + q2.size() + qp.size()) > 0; i++)
      @(negedge clk);
    repeat (4) @(negedge clk);
    compare("pending expected results", q0.size() + q2.size() + qp.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/adc_level_meter.md
# adc_level_meter

Parametrised, clocked successor to the ADC-to-LED bar-graph display. It takes ADC samples qualified by a valid strobe, averages them over a configurable window and quantises the average into `LED_CNT` levels. The result drives the LED bank as a bar or a single dot, with an optional peak-hold marker that decays over time. It sits between the capture ADC interface and the board LEDs, and is used for bring-up and signal-level monitoring.

## Interface
- `ADC_RES`, 12: sample width in bits.
- `LED_CNT`, 8: LED count; power of two, 2..2^ADC_RES; `STEP = 2^ADC_RES / LED_CNT`.
- `AVG_LOG2`, 2: averaging window is 2^AVG_LOG2 samples; legal range 0..4.
- `HOLD_UPDATES`, 64: number of updates the peak is held before it starts decaying.
- `DECAY_UPDATES`, 8: number of updates per one-level peak decay.

Ports:
- `clk` in 1: the single clock; all logic is on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `datain` in ADC_RES: unsigned ADC sample.
- `datavalid` in 1: `datain` is valid this cycle (single-cycle qualifier, no backpressure).
- `dotmode` in 1: 0 = bar display, 1 = dot display.
- `ledsout` out LED_CNT: registered LED drive.
- `level` out clog2(LED_CNT+1): current quantised level, 0..LED_CNT.
- `peak` out clog2(LED_CNT+1): current peak level.
- `update` out 1: one-cycle pulse when `level`/`peak`/`ledsout` take a new window result.

## Operation
- **Reset values:** `ledsout`=0, `level`=0, `peak`=0, `update`=0. The accumulator, window count, hold count and decay count are all cleared.
- **Accumulation:** on `datavalid`, `acc += datain` and the window count increments. `acc` is ADC_RES+AVG_LOG2 bits wide and cannot overflow.
- **Window completion:**
  - The window completes on the 2^AVG_LOG2-th valid sample. With AVG_LOG2=0, every valid sample completes a window.
  - At completion, `avg = (acc + datain) >> AVG_LOG2`. The accumulator and window count clear in the same cycle.
- **Quantisation:** `lvl = (avg + STEP - 1) >> log2(STEP)`, computed at ADC_RES+1 bits. This gives 0 only for avg=0, and gives LED_CNT for avg > (LED_CNT-1)*STEP.
- **Peak tracking** (per completed window; evaluated in this order):
  - If `lvl >= peak`: `peak <= lvl`, hold count <= HOLD_UPDATES, decay count <= 0.
  - Else if hold count > 0: hold count decrements.
  - Else: decay count increments. When it reaches DECAY_UPDATES, `peak` decrements by one (never below `lvl`) and the decay count clears.
- **LED mapping** (L = `level`, P = `peak`):
  - Bar mode: bits [L-1:0] set.
  - Dot mode: only bit L-1 set.
  - L=0: no level bits in either mode.
  - With peak enabled and P>0: bit P-1 is additionally set.
- **Refresh:** `ledsout` is recomputed every cycle from the next-state `level`/`peak` and the current `dotmode`. A `dotmode` change is therefore reflected without waiting for a window.
- **Boundary cases:**
  - `datavalid` during `rst` is ignored.
  - `rst` mid-window discards the partial sum; the next window starts fresh.
  - `datavalid` on consecutive cycles is fully supported (one sample per clock).

## Timing
- Completion on cycle N: `level`, `peak`, `ledsout` and `update`=1 are all valid at cycle N+1. Latency is 1 clock.
- `update` is high for exactly one cycle per completed window and is never asserted otherwise.
- `dotmode` sampled on cycle N appears on `ledsout` at cycle N+1.
- Reset asserted on cycle N: all outputs read reset values at N+1 and remain there while `rst` is high.
- Throughput: one sample per clock. Minimum `update` spacing is 2^AVG_LOG2 cycles.

## Configuration
- `ADC_LEVEL_METER_PEAK_HOLD_EN` defined:
  - Peak tracking, hold and decay counters are built as described.
  - The peak bit is ORed into `ledsout`.
- Not defined:
  - `peak` is tied to 0 and no peak bit appears on `ledsout`.
  - Hold/decay logic is not synthesised; HOLD_UPDATES and DECAY_UPDATES are ignored.
  - All other behaviour is unchanged.

## Test plan
- **Reset:** assert `rst` with `datavalid`=1, `datain`=4095 -> `ledsout`=0x00, `level`=0, `peak`=0, `update`=0 throughout.
- **Quantisation** (AVG_LOG2=0, bar mode, peak disabled): `datain` 0/1/512/513/2000/4095 -> `level` 0/1/1/2/4/8 and `ledsout` 0x00/0x01/0x01/0x03/0x0F/0xFF. Each result arrives with `update` exactly one cycle after `datavalid`.
- **Averaging** (AVG_LOG2=2): samples 0,0,0,4095 on back-to-back cycles -> no `update` for the first three; then avg=1023, `level`=2, `ledsout`=0x03, `update` one cycle after the fourth sample.
- **Peak hold/decay** (macro on, AVG_LOG2=0, HOLD_UPDATES=4, DECAY_UPDATES=2):
  - One 4095 -> `peak`=8.
  - Followed by zeros -> `peak` stays 8 for 4 updates with `ledsout`=0x80.
  - Then `peak` falls 7, 6, ... one level per 2 updates, reaching 0.
- **Dot mode** (macro on): `datain`=2000 after a peak of 8 -> `ledsout`=0x88. Toggle `dotmode` to 0 with no new sample -> `ledsout`=0x8F on the next cycle.
- **Reset mid-window** (AVG_LOG2=2): samples 4095,4095, then `rst` for one cycle, then 0,0,0,0 -> `level`=0, proving the partial sum was discarded.
